// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Two-requester round-robin arbiter and sequencer for the 6-bit address,
//   8-bit data I/O register bus. Each transaction takes three states:
//   IDLE (arbitrate and latch), ISSUE (single-cycle strobe), DONE (ack).
//   Every output is registered.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   req/wr/addr/wdata 0,1 : requester transaction fields, held until ack
//   ack0, ack1            : one-cycle completion pulse per requester
//   rdata0, rdata1        : captured read data, held between reads
//   bus_addr, bus_wdata   : address and write data to the I/O block
//   bus_rdata             : combinational read data from the I/O block
//   bus_re, bus_we        : read / write strobes, high only during ISSUE
//   busy                  : high whenever the sequencer is not in IDLE
module io_bus_arbiter #(
    parameter logic RESET_PTR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [5:0] addr0,
    input  logic [5:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [5:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       bus_re,
    output logic       bus_we,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t state;
    logic   ptr;     // id of the last granted requester
    logic   gnt;     // id of the requester owning the current transaction
    logic   wr_q;    // current transaction is a write
    logic   pick;    // arbitration result, meaningful only when a request is present
    logic   pick_wr;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        pick    = (req0 && req1) ? ~ptr : req1;
        pick_wr = pick ? wr1 : wr0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= RESET_PTR;
            gnt       <= 1'b0;
            wr_q      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt       <= pick;
                        ptr       <= pick;
                        wr_q      <= pick_wr;
                        bus_addr  <= pick ? addr1 : addr0;
                        bus_wdata <= pick ? wdata1 : wdata0;
                        bus_we    <= pick_wr;
                        bus_re    <= ~pick_wr;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // bus_rdata is sampled only at the end of the strobe cycle.
                    if (!wr_q) begin
                        if (gnt) rdata1 <= bus_rdata;
                        else     rdata0 <= bus_rdata;
                    end
                    if (gnt) ack1 <= 1'b1;
                    else     ack0 <= 1'b1;
                    bus_re <= 1'b0;
                    bus_we <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model tracks each grant by the edge number on which it was
//   sampled and derives every expected output from that timestamp.
module tb_io_bus_arbiter;

    localparam logic TB_PTR = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, wr0, wr1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [5:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_re, bus_we, busy;

    logic [7:0] mem [64];
    assign bus_rdata = mem[bus_addr];

    always #5 clk = ~clk;

    io_bus_arbiter #(.RESET_PTR(TB_PTR)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_re(bus_re), .bus_we(bus_we), .busy(busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: transaction-level view keyed by edge number.
    int         edge_n    = 0;
    int         start     = -100;   // edge on which the current grant was sampled
    int         next_free = 0;      // first edge on which a new request may be sampled
    bit         m_ptr, m_g, m_wr, m_valid = 0;
    logic [5:0] e_addr;
    logic [7:0] e_wdata, e_rd0, e_rd1;
    bit         e_re, e_we, e_ack0, e_ack1, e_busy;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        edge_n++;
        if (reset) begin
            m_valid   = 1;
            m_ptr     = TB_PTR;
            start     = -100;
            next_free = edge_n + 1;
            e_addr    = '0;
            e_wdata   = '0;
            e_rd0     = '0;
            e_rd1     = '0;
        end else begin
            if (edge_n >= next_free && (req0 || req1)) begin
                m_g       = (req0 && req1) ? !m_ptr : req1;
                m_ptr     = m_g;
                m_wr      = m_g ? wr1 : wr0;
                e_addr    = m_g ? addr1 : addr0;
                e_wdata   = m_g ? wdata1 : wdata0;
                start     = edge_n;
                next_free = edge_n + 3;
            end
            if (edge_n == start + 1 && !m_wr) begin
                if (m_g) e_rd1 = mem[e_addr];
                else     e_rd0 = mem[e_addr];
            end
        end
        e_re   = !reset && edge_n == start && !m_wr;
        e_we   = !reset && edge_n == start && m_wr;
        e_ack0 = !reset && edge_n == start + 1 && !m_g;
        e_ack1 = !reset && edge_n == start + 1 && m_g;
        e_busy = !reset && (edge_n == start || edge_n == start + 1);
    endtask

    task automatic compare_all();
        chk("bus_re", bus_re, e_re);
        chk("bus_we", bus_we, e_we);
        chk("ack0", ack0, e_ack0);
        chk("ack1", ack1, e_ack1);
        chk("busy", busy, e_busy);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
        chk("rdata0", rdata0, e_rd0);
        chk("rdata1", rdata1, e_rd1);
        chk("strobe_excl", bus_re & bus_we, 8'h00);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) compare_all();
    endtask

    task automatic rnd0();
        wr0 = 1'($urandom_range(1)); addr0 = 6'($urandom); wdata0 = 8'($urandom);
    endtask

    task automatic rnd1();
        wr1 = 1'($urandom_range(1)); addr1 = 6'($urandom); wdata1 = 8'($urandom);
    endtask

    int order[$];
    int pulses[$];
    int acks;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[2] = 8'h15;
        reset = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset then single read
        cycle(); cycle();
        chk("rst_busy", busy, 8'h00);
        chk("rst_addr", bus_addr, 8'h00);
        reset = 1'b0;
        req0 = 1; wr0 = 0; addr0 = 6'h02;
        cycle();
        chk("rd_re", bus_re, 8'h01);
        chk("rd_addr", bus_addr, 8'h02);
        cycle();
        chk("rd_ack0", ack0, 8'h01);
        chk("rd_data", rdata0, 8'h15);
        chk("rd_ack1", ack1, 8'h00);
        req0 = 0;
        cycle();

        // Single write from requester 1
        req1 = 1; wr1 = 1; addr1 = 6'h04; wdata1 = 8'hA5;
        cycle();
        chk("wr_we", bus_we, 8'h01);
        chk("wr_re", bus_re, 8'h00);
        chk("wr_wdata", bus_wdata, 8'hA5);
        cycle();
        chk("wr_ack1", ack1, 8'h01);
        chk("wr_rdata1", rdata1, 8'h00);
        req1 = 0;
        cycle();

        // Simultaneous requests after reset: 0,1,0,1 with 3-cycle spacing
        reset = 1; cycle(); reset = 0;
        req0 = 1; wr0 = 0; addr0 = 6'h01;
        req1 = 1; wr1 = 1; addr1 = 6'h03; wdata1 = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            if (bus_re || bus_we) pulses.push_back(i);
        end
        req0 = 0; req1 = 0;
        chk("rr_count", 8'(order.size()), 8'd4);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 8'(order[i]), 8'(i % 2));
        for (int i = 1; i < pulses.size(); i++) chk("rr_gap", 8'(pulses[i] - pulses[i-1]), 8'd3);
        cycle(); cycle();

        // Held request: three reads, dropped on the third ack
        pulses.delete();
        acks = 0;
        req0 = 1; wr0 = 0; addr0 = 6'h05;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus_re) pulses.push_back(i);
            if (ack0) begin
                acks++;
                if (acks == 3) req0 = 0;
            end
        end
        chk("held_pulses", 8'(pulses.size()), 8'd3);
        for (int i = 1; i < pulses.size(); i++) chk("held_gap", 8'(pulses[i] - pulses[i-1]), 8'd3);

        // Reset during ISSUE of a read
        req0 = 1; wr0 = 0; addr0 = 6'h06;
        cycle();
        chk("mid_re", bus_re, 8'h01);
        reset = 1; req0 = 0;
        cycle();
        chk("mid_re0", bus_re, 8'h00);
        chk("mid_busy0", busy, 8'h00);
        chk("mid_rdata0", rdata0, 8'h00);
        reset = 0;
        cycle(); cycle();
        req0 = 1; wr0 = 0; addr0 = 6'h09;
        req1 = 1; wr1 = 0; addr1 = 6'h0A;
        cycle(); cycle();
        chk("mid_first_ack0", ack0, 8'h01);
        chk("mid_first_ack1", ack1, 8'h00);
        req0 = 0;
        cycle(); cycle(); cycle();
        chk("mid_second_ack1", ack1, 8'h01);
        req1 = 0;
        cycle();

        // Late req1 during a requester-0 write
        req0 = 1; wr0 = 1; addr0 = 6'h07; wdata0 = 8'h3C;
        cycle();
        req1 = 1; wr1 = 0; addr1 = 6'h08;
        chk("late_addr0", bus_addr, 8'h07);
        cycle();
        chk("late_ack0", ack0, 8'h01);
        req0 = 0;
        cycle();
        chk("late_idle", busy, 8'h00);
        cycle();
        chk("late_re1", bus_re, 8'h01);
        chk("late_addr1", bus_addr, 8'h08);
        cycle();
        chk("late_ack1", ack1, 8'h01);
        chk("late_rdata1", rdata1, mem[8]);
        req1 = 0;
        cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            if (req0 && ack0) begin
                req0 = 1'($urandom_range(1));
                rnd0();
            end else if (!req0 && $urandom_range(2) == 0) begin
                req0 = 1;
                rnd0();
            end
            if (req1 && ack1) begin
                req1 = 1'($urandom_range(1));
                rnd1();
            end else if (!req1 && $urandom_range(2) == 0) begin
                req1 = 1;
                rnd1();
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-requester arbiter and sequencer for the 6-bit-address, 8-bit-data I/O register bus that feeds the on-board I/O block (switches, buttons, keypad, LEDs, display). It lets the CPU data port and a second master (debug/UART bridge) share one bus. It serialises their transactions with round-robin fairness and drives single-cycle `re`/`we` strobes. Read data is captured and returned to the winning requester with a one-cycle acknowledge.

## Interface
- `RESET_PTR`, default 1'b1: round-robin "last granted" pointer value after reset. A value of 1 makes requester 0 win the first tie.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1 each: transaction request; must be held with fields stable until the matching ack.
- `wr0`, `wr1` input 1 each: 1 = write, 0 = read.
- `addr0`, `addr1` input 6 each: target port address.
- `wdata0`, `wdata1` input 8 each: write data.
- `ack0`, `ack1` output 1 each: one-cycle completion pulse.
- `rdata0`, `rdata1` output 8 each: read data, valid while the matching ack is high; holds its value otherwise.
- `bus_addr` output 6: address to the I/O block.
- `bus_wdata` output 8: data to the I/O block (`data_in` side).
- `bus_rdata` input 8: combinational read data from the I/O block (`data_out` side).
- `bus_re`, `bus_we` output 1 each: read and write strobes.
- `busy` output 1: high in any state other than IDLE.

## Operation
- All outputs are registered.
- FSM states: IDLE, ISSUE, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the one not equal to the pointer.
  - On grant: latch grant id, `addr`, `wr`, and `wdata` into `bus_addr`/`bus_wdata`. Set `bus_we = wr` and `bus_re = !wr`. Update pointer to the grant id. Go to ISSUE.
- **ISSUE:**
  - Exactly one of `bus_re`/`bus_we` is high for exactly this one cycle.
  - At the closing edge, if read, capture `bus_rdata` into `rdata<g>`.
  - Clear both strobes, assert `ack<g>`, go to DONE.
- **DONE:**
  - `ack<g>` is high for this cycle only.
  - `bus_addr`/`bus_wdata` hold their values.
  - Go to IDLE.
- The non-granted requester's ack and rdata are untouched.
- `rdata` is not updated on a write.
- Requests are sampled only in IDLE. Changes to `req` during ISSUE/DONE have no effect.
- `bus_re` and `bus_we` are never high together and never high outside ISSUE. This guarantees a single read strobe per transaction for read-side-effect ports.
- Reset, including mid-transaction, forces:
  - state IDLE
  - all strobes, acks and `busy` to 0
  - `bus_addr`, `bus_wdata`, `rdata0`, `rdata1` to 0
  - pointer to `RESET_PTR`
- An aborted transaction is never acked. A write aborted during ISSUE may or may not have reached the device.

## Timing
- Request seen high at edge E (in IDLE) gives the following:
  - Strobes and `busy` high in cycle E+1 (ISSUE).
  - Ack and rdata valid in cycle E+2 (DONE).
  - Back in IDLE at E+3.
- Fixed latency: 2 cycles from request-sampling edge to ack.
- Throughput: 1 transaction per 3 cycles.
- A registered requester that drops `req` on the edge where it samples ack is not re-granted.
- A requester holding `req` high through IDLE starts a new transaction at once.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1…. Neither waits more than one transaction.
- `bus_rdata` must settle within the ISSUE cycle; it is sampled only at the end of ISSUE.

## Test plan
- **Reset then single read:** hold `reset` 2 cycles, then `req0`=1, `wr0`=0, `addr0`=0x02, device returns 0x15. Expect:
  - `bus_re` high one cycle with `bus_addr`=0x02;
  - `ack0` pulse 2 cycles after sampling with `rdata0`=0x15;
  - `ack1` stays 0.
- **Single write:** `req1`, `wr1`=1, `addr1`=0x04, `wdata1`=0xA5. Expect:
  - one `bus_we` cycle with `bus_wdata`=0xA5 and `bus_re`=0 throughout;
  - `ack1` pulse;
  - `rdata1` unchanged.
- **Simultaneous requests after reset:** `req0` and `req1` both held, 4 transactions. Expect grant order 0,1,0,1; one transaction every 3 cycles; strobes never overlap.
- **Held request:** `req0` held for 3 acks. Expect exactly 3 `bus_re` pulses, 3 cycles apart. Dropping `req0` on the third ack yields no fourth strobe.
- **Reset mid-operation:** assert `reset` during ISSUE of a read. Expect:
  - next cycle all strobes, acks and `busy` at 0, `rdata` at 0;
  - no ack for the aborted transaction;
  - the next simultaneous request is granted to requester 0.
- **Late request change:** toggle `req1` high during ISSUE of a requester-0 transaction. Expect it ignored until IDLE, then granted at the next IDLE edge.
